// File: rtl/stage_wb_if.sv
// Write-back stage bus: MEM-stage control/data in, register-file write port
// and hazard/forwarding signals out. The master side drives the stage inputs,
// the slave side is the write-back stage itself.
interface stage_wb_if #(
  parameter int DATA_W = 32
);
  logic              Stall;
  logic              Flush;
  logic              RegWrite_in;
  logic              MemtoReg_in;
  logic              RegDst_in;
  logic              MemRead_in;
  logic [4:0]        rt_in;
  logic [4:0]        rd_in;
  logic [DATA_W-1:0] ALUResult_in;
  logic [DATA_W-1:0] MemReadData_in;
  logic              MemDataValid;
  logic              RegWrite_out;
  logic [4:0]        WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              WB_Busy;
  logic              MemTimeout;
  logic [4:0]        ID_rs;
  logic [4:0]        ID_rt;
  logic              FwdA;
  logic              FwdB;

  modport master (
    output Stall, Flush, RegWrite_in, MemtoReg_in, RegDst_in, MemRead_in,
           rt_in, rd_in, ALUResult_in, MemReadData_in, MemDataValid,
           ID_rs, ID_rt,
    input  RegWrite_out, WriteRegister, WriteData, WB_Busy, MemTimeout,
           FwdA, FwdB
  );

  modport slave (
    input  Stall, Flush, RegWrite_in, MemtoReg_in, RegDst_in, MemRead_in,
           rt_in, rd_in, ALUResult_in, MemReadData_in, MemDataValid,
           ID_rs, ID_rt,
    output RegWrite_out, WriteRegister, WriteData, WB_Busy, MemTimeout,
           FwdA, FwdB
  );
endinterface

// File: rtl/stage_wb.sv
// Pipeline write-back stage. Selects destination register and write data,
// waits (with a 15-cycle timeout) for late data-memory reads, and produces a
// one-cycle register-file write pulse per retired instruction.
// Optional feature macro: WB_FWD_EN -- when defined, FwdA/FwdB compare the
// registered write port against ID_rs/ID_rt; otherwise both are tied to 0.
module stage_wb #(
  parameter int DATA_W = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  stage_wb_if.slave  wb
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'd14;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [4:0]        pend_reg, pend_reg_nxt;
  logic              pend_we, pend_we_nxt;

  logic              we_p0, we_nxt;
  logic [4:0]        wr_reg_p0, wr_reg_nxt;
  logic [DATA_W-1:0] wr_data_p0, wr_data_nxt;
  logic              busy_p0, busy_nxt;
  logic              timeout_p0, timeout_nxt;

  logic [4:0]        dest;
  logic [DATA_W-1:0] src_data;
  logic              load_miss;

  assign dest      = wb.RegDst_in ? wb.rd_in : wb.rt_in;
  assign src_data  = wb.MemtoReg_in ? wb.MemReadData_in : wb.ALUResult_in;
  assign load_miss = wb.MemRead_in & wb.MemtoReg_in & ~wb.MemDataValid;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next-output decode; Flush overrides everything else
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pend_reg_nxt = pend_reg;
    pend_we_nxt  = pend_we;
    we_nxt       = 1'b0;
    wr_reg_nxt   = wr_reg_p0;
    wr_data_nxt  = wr_data_p0;
    busy_nxt     = busy_p0;
    timeout_nxt  = timeout_p0;

    if (wb.Flush) begin
      state_nxt   = IDLE;
      cnt_nxt     = 4'd0;
      wr_reg_nxt  = 5'd0;
      wr_data_nxt = '0;
      busy_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wb.Stall) begin
            // hold write port, suppress a duplicate write
            we_nxt = 1'b0;
          end else if (load_miss) begin
            pend_reg_nxt = dest;
            pend_we_nxt  = wb.RegWrite_in;
            busy_nxt     = 1'b1;
            cnt_nxt      = 4'd0;
            state_nxt    = WAIT_MEM;
          end else begin
            wr_reg_nxt  = dest;
            wr_data_nxt = src_data;
            we_nxt      = wb.RegWrite_in & (dest != 5'd0);
            busy_nxt    = 1'b0;
          end
        end
        WAIT_MEM: begin
          if (wb.MemDataValid) begin
            wr_reg_nxt  = pend_reg;
            wr_data_nxt = wb.MemReadData_in;
            we_nxt      = pend_we & (pend_reg != 5'd0);
            busy_nxt    = 1'b0;
            cnt_nxt     = 4'd0;
            state_nxt   = IDLE;
          end else if (cnt == LAST_WAIT) begin
            // 15th empty wait cycle: drop the load and flag it
            timeout_nxt = 1'b1;
            busy_nxt    = 1'b0;
            cnt_nxt     = 4'd0;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered outputs, wait counter and pending-load bookkeeping
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt        <= 4'd0;
      pend_reg   <= 5'd0;
      pend_we    <= 1'b0;
      we_p0      <= 1'b0;
      wr_reg_p0  <= 5'd0;
      wr_data_p0 <= '0;
      busy_p0    <= 1'b0;
      timeout_p0 <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      pend_reg   <= pend_reg_nxt;
      pend_we    <= pend_we_nxt;
      we_p0      <= we_nxt;
      wr_reg_p0  <= wr_reg_nxt;
      wr_data_p0 <= wr_data_nxt;
      busy_p0    <= busy_nxt;
      timeout_p0 <= timeout_nxt;
    end
  end

  assign wb.RegWrite_out  = we_p0;
  assign wb.WriteRegister = wr_reg_p0;
  assign wb.WriteData     = wr_data_p0;
  assign wb.WB_Busy       = busy_p0;
  assign wb.MemTimeout    = timeout_p0;

`ifdef WB_FWD_EN
  assign wb.FwdA = we_p0 & (wr_reg_p0 == wb.ID_rs) & (wb.ID_rs != 5'd0);
  assign wb.FwdB = we_p0 & (wr_reg_p0 == wb.ID_rt) & (wb.ID_rt != 5'd0);
`else
  logic unused_id;
  assign unused_id = ^{wb.ID_rs, wb.ID_rt};
  assign wb.FwdA   = 1'b0;
  assign wb.FwdB   = 1'b0;
`endif

endmodule

// File: tb/tb_stage_wb.sv
// Directed testbench for stage_wb: reset values, R-type write, $zero guard,
// stall hold, delayed load, flush, timeout stickiness, async reset mid-load
// and forwarding compare.
module tb_stage_wb;

`ifdef WB_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic Clk;
  logic Reset;
  int   n_tests;
  int   n_fail;

  stage_wb_if #(.DATA_W(32)) bus ();

  stage_wb #(.DATA_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .wb    (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bubble();
    bus.Stall = 0; bus.Flush = 0;
    bus.RegWrite_in = 0; bus.MemtoReg_in = 0; bus.RegDst_in = 0; bus.MemRead_in = 0;
    bus.rt_in = 0; bus.rd_in = 0; bus.ALUResult_in = 0; bus.MemReadData_in = 0;
    bus.MemDataValid = 0;
  endtask

  task automatic rtype(input logic [4:0] rd, input logic [31:0] alu);
    bubble();
    bus.RegDst_in = 1; bus.rd_in = rd; bus.rt_in = 5'd3;
    bus.RegWrite_in = 1; bus.ALUResult_in = alu;
  endtask

  task automatic load(input logic [4:0] rt);
    bubble();
    bus.RegWrite_in = 1; bus.MemRead_in = 1; bus.MemtoReg_in = 1;
    bus.rt_in = rt; bus.rd_in = 5'd17; bus.ALUResult_in = 32'h1234_5678;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_we"},   {31'd0, bus.RegWrite_out}, 32'd0);
    chk({tag, "_reg"},  {27'd0, bus.WriteRegister}, 32'd0);
    chk({tag, "_data"}, bus.WriteData, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.WB_Busy}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bubble();
    bus.ID_rs = 5'd8;
    bus.ID_rt = 5'd9;
    Reset = 1'b0;

    // reset state before any clock edge
    #2;
    all_zero("rst");
    chk("rst_tmo",  {31'd0, bus.MemTimeout}, 32'd0);
    chk("rst_fwda", {31'd0, bus.FwdA}, 32'd0);
    chk("rst_fwdb", {31'd0, bus.FwdB}, 32'd0);
    #10 Reset = 1'b1;

    // R-type write to r8, one-cycle pulse, forwarding compare
    rtype(5'd8, 32'h0000_002A);
    tick();
    chk("rt_we",   {31'd0, bus.RegWrite_out}, 32'd1);
    chk("rt_reg",  {27'd0, bus.WriteRegister}, 32'd8);
    chk("rt_data", bus.WriteData, 32'h0000_002A);
    chk("rt_fwda", {31'd0, bus.FwdA}, {31'd0, FWD});
    chk("rt_fwdb", {31'd0, bus.FwdB}, 32'd0);
    bubble();
    tick();
    chk("rt_pulse", {31'd0, bus.RegWrite_out}, 32'd0);
    chk("rt_fwda_off", {31'd0, bus.FwdA}, 32'd0);

    // write to $zero is suppressed
    rtype(5'd0, 32'h0000_0055);
    tick();
    chk("zero_we",   {31'd0, bus.RegWrite_out}, 32'd0);
    chk("zero_data", bus.WriteData, 32'h0000_0055);

    // stall in IDLE holds write port and blocks duplicate write
    rtype(5'd5, 32'h0000_0011);
    tick();
    chk("pre_stall_we", {31'd0, bus.RegWrite_out}, 32'd1);
    rtype(5'd6, 32'h0000_0022);
    bus.Stall = 1;
    tick();
    chk("stall_we",   {31'd0, bus.RegWrite_out}, 32'd0);
    chk("stall_reg",  {27'd0, bus.WriteRegister}, 32'd5);
    chk("stall_data", bus.WriteData, 32'h0000_0011);

    // load with data arriving after 3 busy cycles
    load(5'd9);
    tick();
    chk("ld_busy0", {31'd0, bus.WB_Busy}, 32'd1);
    chk("ld_we0",   {31'd0, bus.RegWrite_out}, 32'd0);
    bubble();
    bus.Stall = 1;
    tick();
    chk("ld_busy1", {31'd0, bus.WB_Busy}, 32'd1);
    tick();
    chk("ld_busy2", {31'd0, bus.WB_Busy}, 32'd1);
    bus.MemDataValid = 1; bus.MemReadData_in = 32'hDEAD_BEEF;
    tick();
    chk("ld_we",   {31'd0, bus.RegWrite_out}, 32'd1);
    chk("ld_reg",  {27'd0, bus.WriteRegister}, 32'd9);
    chk("ld_data", bus.WriteData, 32'hDEAD_BEEF);
    chk("ld_busy", {31'd0, bus.WB_Busy}, 32'd0);
    chk("ld_fwdb", {31'd0, bus.FwdB}, {31'd0, FWD});
    bubble();
    tick();
    chk("ld_pulse", {31'd0, bus.RegWrite_out}, 32'd0);

    // flush in WAIT_MEM wins over MemDataValid
    load(5'd10);
    tick();
    chk("fl_busy0", {31'd0, bus.WB_Busy}, 32'd1);
    bubble();
    bus.Flush = 1; bus.MemDataValid = 1; bus.MemReadData_in = 32'hCAFE_F00D;
    tick();
    all_zero("fl_wait");
    bubble();
    bus.MemDataValid = 1; bus.MemReadData_in = 32'hCAFE_F00D;
    tick();
    chk("fl_noreplay", {31'd0, bus.RegWrite_out}, 32'd0);

    // flush + stall on a valid R-type
    rtype(5'd7, 32'h0000_0077);
    tick();
    chk("pre_fl_we", {31'd0, bus.RegWrite_out}, 32'd1);
    rtype(5'd8, 32'h0000_0099);
    bus.Flush = 1; bus.Stall = 1;
    tick();
    all_zero("flst");

    // load timeout after 15 empty wait cycles
    load(5'd12);
    tick();
    bubble();
    for (int i = 0; i < 14; i++) tick();
    chk("to_busy14", {31'd0, bus.WB_Busy}, 32'd1);
    chk("to_tmo14",  {31'd0, bus.MemTimeout}, 32'd0);
    tick();
    chk("to_tmo",  {31'd0, bus.MemTimeout}, 32'd1);
    chk("to_busy", {31'd0, bus.WB_Busy}, 32'd0);
    chk("to_we",   {31'd0, bus.RegWrite_out}, 32'd0);
    bus.MemDataValid = 1; bus.MemReadData_in = 32'h0BAD_0BAD;
    tick();
    chk("to_late_we", {31'd0, bus.RegWrite_out}, 32'd0);
    rtype(5'd4, 32'h0000_0044);
    tick();
    chk("to_sticky", {31'd0, bus.MemTimeout}, 32'd1);
    chk("to_rt_we",  {31'd0, bus.RegWrite_out}, 32'd1);

    // asynchronous reset mid-WAIT_MEM
    load(5'd13);
    tick();
    chk("rm_busy", {31'd0, bus.WB_Busy}, 32'd1);
    chk("rm_reg",  {27'd0, bus.WriteRegister}, 32'd4);
    bubble();
    #2 Reset = 1'b0;
    #1;
    all_zero("rm");
    chk("rm_tmo", {31'd0, bus.MemTimeout}, 32'd0);
    #2 Reset = 1'b1;
    bus.MemDataValid = 1; bus.MemReadData_in = 32'h1111_2222;
    tick();
    chk("rm_discard", {31'd0, bus.RegWrite_out}, 32'd0);
    chk("rm_idle",    {31'd0, bus.WB_Busy}, 32'd0);
    rtype(5'd8, 32'h0000_0123);
    tick();
    chk("rm_resume_we",   {31'd0, bus.RegWrite_out}, 32'd1);
    chk("rm_resume_data", bus.WriteData, 32'h0000_0123);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
